control_sequencer: RTL and testbench

- Hardwired control unit driving every datapath/memory control input of the System block (bus out/in enables, ALU opcode, register-select, memory strobes).
- Replaces hand-written testbench state sequences: fetches, decodes IR[31:27], steps T0..T7 per instruction, waits on memory_done for memory cycles.
- Sits directly upstream of the datapath; consumes IR opcode and memory_done, produces control signals.

---
 rtl/control_sequencer_if.sv | 32 +++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the System datapath/memory.
// The sequencer (master) consumes IR and memory_done and drives every control line.
interface control_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] IR;
    logic                  memory_done;

    logic PCout, MDRout, Zhi_out, Zlo_out, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
    logic Gra, Grb, Grc, IncPC;
    logic [4:0] opcode;
    logic Mem_Read, Mem_Write, Mem_enable512x32;
    logic run;
    logic fault;

    modport master (
        input  IR, memory_done,
        output PCout, MDRout, Zhi_out, Zlo_out, Cout, BAout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
        output Gra, Grb, Grc, IncPC, opcode,
        output Mem_Read, Mem_Write, Mem_enable512x32, run, fault
    );

    modport slave (
        output IR, memory_done,
        input  PCout, MDRout, Zhi_out, Zlo_out, Cout, BAout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
        input  Gra, Grb, Grc, IncPC, opcode,
        input  Mem_Read, Mem_Write, Mem_enable512x32, run, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0..T2), decode in T3, per-class execute
// steps up to T7, memory waits with timeout, sticky fault and halt.
// ld and st get their own T4..T7 states so no class register is needed.
module control_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               Clock,
    input  logic               clear,
    control_sequencer_if.master bus
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3,
        S_A4, S_A5,
        S_LD4, S_LD5, S_LD6, S_LD7,
        S_ST4, S_ST5, S_ST6, S_ST7,
        S_HALT
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic [4:0] opcode_q, opcode_d;

    logic [4:0] ir_op;
    logic       md;
    logic       timeout;
    logic       is_alu;
    logic       unused_ir;

    assign ir_op     = bus.IR[DATA_WIDTH-1 -: 5];
    assign unused_ir = ^bus.IR[DATA_WIDTH-6:0];
    assign md        = bus.memory_done;
    assign timeout   = (cnt_q == CNT_LAST);
    assign is_alu    = (ir_op == OP_ADDI) || (ir_op == OP_ORI) || (ir_op == OP_ANDI);

    // State, wait counter, sticky fault and held ALU opcode registers
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_T0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            opcode_q <= opcode_d;
        end
    end

    // Next state; the counter is zero outside waits, so every wait starts at 0
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        fault_d  = fault_q;
        opcode_d = opcode_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: begin
                if (md)           state_d = S_T2;
                else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
                else              cnt_d = cnt_q + 8'd1;
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (is_alu) begin
                    state_d  = S_A4;
                    opcode_d = ir_op;
                end else if (ir_op == OP_LD) begin
                    state_d  = S_LD4;
                    opcode_d = OP_ADDI;
                end else if (ir_op == OP_ST) begin
                    state_d  = S_ST4;
                    opcode_d = OP_ADDI;
                end else if (ir_op == OP_NOP) begin
                    state_d = S_T0;
                end else if (ir_op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_A4:  state_d = S_A5;
            S_A5:  state_d = S_T0;
            S_LD4: state_d = S_LD5;
            S_LD5: state_d = S_LD6;
            S_LD6: begin
                if (md)           state_d = S_LD7;
                else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
                else              cnt_d = cnt_q + 8'd1;
            end
            S_LD7: state_d = S_T0;
            S_ST4: state_d = S_ST5;
            S_ST5: state_d = S_ST6;
            S_ST6: state_d = S_ST7;
            S_ST7: begin
                if (md)           state_d = S_T0;
                else if (timeout) begin state_d = S_HALT; fault_d = 1'b1; end
                else              cnt_d = cnt_q + 8'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Control decode of the current state; T3 also looks at the live opcode
    always_comb begin
        bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zhi_out = 1'b0; bus.Zlo_out = 1'b0;
        bus.Cout = 1'b0;  bus.BAout = 1'b0;  bus.Rout = 1'b0;
        bus.MARin = 1'b0; bus.Zin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0;
        bus.IRin = 1'b0;  bus.Yin = 1'b0; bus.Rin = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.IncPC = 1'b0;
        bus.Mem_Read = 1'b0; bus.Mem_Write = 1'b0; bus.Mem_enable512x32 = 1'b0;
        if (clear) begin
            case (state_q)
                S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
                S_T1: begin
                    bus.Zlo_out = 1'b1; bus.MDRin = 1'b1;
                    bus.Mem_Read = 1'b1; bus.Mem_enable512x32 = 1'b1;
                    bus.PCin = (cnt_q == 8'd0);
                end
                S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
                S_T3: begin
                    if (is_alu) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end else if (ir_op == OP_LD || ir_op == OP_ST) begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end
                end
                S_A4, S_LD4, S_ST4: begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
                S_A5:  begin bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                S_LD5, S_ST5: begin bus.Zlo_out = 1'b1; bus.MARin = 1'b1; end
                S_LD6: begin bus.Mem_Read = 1'b1; bus.Mem_enable512x32 = 1'b1; bus.MDRin = 1'b1; end
                S_LD7: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                S_ST6: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                S_ST7: begin bus.Mem_Write = 1'b1; bus.Mem_enable512x32 = 1'b1; end
                default: ;
            endcase
        end
    end

    // Halt blanks the opcode; elsewhere it holds the value loaded on entry to T4
    assign bus.opcode = (state_q == S_HALT) ? 5'b00000 : opcode_q;
    assign bus.run    = (state_q != S_HALT);
    assign bus.fault  = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model expands each
// instruction into per-cycle expected control words, the driver applies the
// inputs and queues the expectations, and a negedge monitor compares.
module tb_control_sequencer;
    localparam int TO = 20;

    logic Clock = 1'b0;
    logic clear;

    control_sequencer_if #(.DATA_WIDTH(32)) bus();
    control_sequencer #(.DATA_WIDTH(32), .MEM_TIMEOUT(TO)) dut (
        .Clock(Clock), .clear(clear), .bus(bus.master)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic PCout, MDRout, Zhi_out, Zlo_out, Cout, BAout, Rout;
        logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
        logic Gra, Grb, Grc, IncPC;
        logic Mem_Read, Mem_Write, Mem_en;
        logic run, fault;
        logic [4:0] opcode;
    } ctl_t;

    typedef struct {
        logic        clr;
        logic        md;
        logic [31:0] ir;
        ctl_t        exp;
    } item_t;

    item_t plan[$];
    item_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Architectural model state
    logic       m_fault;
    logic [4:0] m_op;

    function automatic logic [31:0] rnd_ir();
        return $urandom();
    endfunction

    function automatic logic rmd();
        return ($urandom_range(0, 1) != 0);
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.run = 1'b1;
        c.fault = m_fault;
        c.opcode = m_op;
        return c;
    endfunction

    task automatic add(input logic [31:0] ir, input logic md, input ctl_t c);
        item_t it;
        it.clr = 1'b1; it.md = md; it.ir = ir; it.exp = c;
        plan.push_back(it);
    endtask

    task automatic gen_reset(input int n);
        item_t it;
        m_fault = 1'b0;
        m_op = 5'b0;
        for (int i = 0; i < n; i++) begin
            it.clr = 1'b0; it.md = rmd(); it.ir = rnd_ir();
            it.exp = '0; it.exp.run = 1'b1;
            plan.push_back(it);
        end
    endtask

    task automatic gen_halt(input int n);
        ctl_t c;
        for (int i = 0; i < n; i++) begin
            c = '0; c.fault = m_fault;
            add(rnd_ir(), rmd(), c);
        end
    endtask

    // Memory wait: done arrives after d idle cycles; TO idle cycles means fault
    task automatic gen_wait(input logic [31:0] ir, input int d, input ctl_t c, output bit to);
        ctl_t cc;
        to = 1'b1;
        for (int i = 0; i < TO; i++) begin
            cc = c;
            if (i != 0) cc.PCin = 1'b0;
            add(ir, (i == d), cc);
            if (i == d) begin to = 1'b0; break; end
        end
        if (to) m_fault = 1'b1;
    endtask

    // Expand one instruction; returns early when the machine halts
    task automatic gen_instr(input logic [31:0] ir, input int d1, input int d2);
        logic [4:0] op;
        ctl_t c;
        bit   to, alu, mem;
        op  = ir[31:27];
        alu = (op == 5'd3) || (op == 5'd10) || (op == 5'd11);
        mem = (op == 5'd0) || (op == 5'd1);
        c = base(); c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1;
        add(rnd_ir(), rmd(), c);
        c = base(); c.Zlo_out = 1; c.PCin = 1; c.MDRin = 1; c.Mem_Read = 1; c.Mem_en = 1;
        gen_wait(rnd_ir(), d1, c, to);
        if (to) return;
        c = base(); c.MDRout = 1; c.IRin = 1;
        add(rnd_ir(), rmd(), c);
        c = base();
        if (alu) begin c.Grb = 1; c.Rout = 1; c.Yin = 1; end
        if (mem) begin c.Grb = 1; c.BAout = 1; c.Yin = 1; end
        add(ir, rmd(), c);
        if (op == 5'b11010 || op == 5'b11011) return;
        if (!alu && !mem) begin m_fault = 1'b1; return; end
        m_op = alu ? op : 5'b00011;
        c = base(); c.Cout = 1; c.Zin = 1;
        add(ir, rmd(), c);
        c = base(); c.Zlo_out = 1;
        if (alu) begin c.Gra = 1; c.Rin = 1; end else c.MARin = 1;
        add(ir, rmd(), c);
        if (alu) return;
        if (op == 5'd0) begin
            c = base(); c.Mem_Read = 1; c.Mem_en = 1; c.MDRin = 1;
            gen_wait(ir, d2, c, to);
            if (to) return;
            c = base(); c.MDRout = 1; c.Gra = 1; c.Rin = 1;
            add(ir, rmd(), c);
        end else begin
            c = base(); c.Gra = 1; c.Rout = 1; c.MDRin = 1;
            add(ir, rmd(), c);
            c = base(); c.Mem_Write = 1; c.Mem_en = 1;
            gen_wait(ir, d2, c, to);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op);
        logic [31:0] r = $urandom();
        r[31:27] = op;
        return r;
    endfunction

    // Monitor: compare the DUT control word against the queued expectation
    ctl_t  got;
    item_t mit;
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            mit = exp_q.pop_front();
            got = {bus.PCout, bus.MDRout, bus.Zhi_out, bus.Zlo_out, bus.Cout, bus.BAout, bus.Rout,
                   bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Rin,
                   bus.Gra, bus.Grb, bus.Grc, bus.IncPC,
                   bus.Mem_Read, bus.Mem_Write, bus.Mem_enable512x32,
                   bus.run, bus.fault, bus.opcode};
            n_tests++;
            if (got !== mit.exp) begin
                n_fail++;
                $display("FAIL ctl cycle %0d: got %b, expected %b", cyc, got, mit.exp);
            end
            cyc++;
        end
    end

    initial begin
        logic [4:0] legal [6];
        int sz;
        legal = '{5'd3, 5'd10, 5'd11, 5'd0, 5'd1, 5'd26};
        clear = 1'b0;
        bus.IR = '0;
        bus.memory_done = 1'b0;
        #1 clear = 1'b1;
        #1 clear = 1'b0;

        gen_reset(3);
        gen_instr(32'h19A7FFFB, 0, 0);
        gen_instr(32'h19A7FFFB, 0, 0);
        gen_instr(32'h59A00053, 0, 0);
        gen_instr(32'h51A00053, 0, 0);
        gen_instr(mk(5'd0), 3, 3);
        gen_instr(mk(5'd1), 2, 0);
        gen_instr(mk(5'd0), TO - 1, TO - 1);
        for (int i = 0; i < 40; i++)
            gen_instr(mk(legal[$urandom_range(0, 5)]), $urandom_range(0, 5), $urandom_range(0, 5));
        // st whose write never completes
        gen_instr(mk(5'd1), 0, TO + 5);
        gen_halt(50);
        gen_reset(2);
        // illegal opcode then halt opcode
        gen_instr(mk(5'b11111), 1, 0);
        gen_halt(50);
        gen_reset(2);
        gen_instr(mk(5'b11011), 0, 0);
        gen_halt(50);
        gen_reset(2);
        // fetch that never completes
        gen_instr(mk(5'd3), TO + 5, 0);
        gen_halt(10);
        gen_reset(2);
        // clear pulsed two cycles into the ld T6 wait
        sz = plan.size();
        gen_instr(mk(5'd0), 0, 8);
        while (plan.size() > sz + 8) void'(plan.pop_back());
        gen_reset(1);
        gen_instr(32'h19A7FFFB, 0, 0);
        for (int i = 0; i < 10; i++)
            gen_instr(mk(legal[$urandom_range(0, 5)]), $urandom_range(0, 3), $urandom_range(0, 3));

        @(posedge Clock); #1;
        foreach (plan[i]) begin
            clear = plan[i].clr;
            bus.IR = plan[i].ir;
            bus.memory_done = plan[i].md;
            exp_q.push_back(plan[i]);
            @(posedge Clock); #1;
        end
        @(negedge Clock); #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
